rv32_ifetch: RTL and testbench

Instruction fetch unit for the 5-stage RV32 core. It consumes the fetch address and redirect/halt controls produced by the PC stage and issues one word-addressed request at a time to instruction memory over a req/ready + rvalid handshake. It presents the returned instruction word to the IF/ID register and holds the PC stage with `busy` until that instruction is consumed. It discards responses made stale by a branch redirect (`flush`).

---
 rtl/rv32_ifetch.sv | 145 ++++++++++++++
 tb/tb_rv32_ifetch.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_ifetch.sv
// Instruction fetch unit: one outstanding word request to instruction memory,
// holds the fetched word for IF/ID and drops responses made stale by a redirect.
module rv32_ifetch #(
    parameter int unsigned DROP_CNT_W = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           pc,
    input  logic                  flush,
    input  logic                  halt,
    output logic                  busy,
    output logic                  mem_req,
    output logic [31:0]           mem_addr,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    input  logic                  id_stall,
    output logic [31:0]           instr,
    output logic [31:0]           instr_pc,
    output logic                  instr_valid,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam int unsigned XLEN = 32;
    localparam logic [DROP_CNT_W-1:0] DROP_MAX = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD
    } state_t;

    state_t                r_state;
    state_t                w_state_nx;
    logic [XLEN-1:0]       r_addr;
    logic [XLEN-1:0]       w_addr_nx;
    logic                  r_drop;
    logic                  w_drop_nx;
    logic                  r_mem_req;
    logic                  w_mem_req_nx;
    logic [XLEN-1:0]       r_instr;
    logic [XLEN-1:0]       w_instr_nx;
    logic [XLEN-1:0]       r_instr_pc;
    logic [XLEN-1:0]       w_instr_pc_nx;
    logic                  r_instr_valid;
    logic                  w_instr_valid_nx;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic [DROP_CNT_W-1:0] w_drop_cnt_nx;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_drop        <= 1'b0;
            r_mem_req     <= 1'b0;
            r_instr       <= '0;
            r_instr_pc    <= '0;
            r_instr_valid <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            r_state       <= w_state_nx;
            r_addr        <= w_addr_nx;
            r_drop        <= w_drop_nx;
            r_mem_req     <= w_mem_req_nx;
            r_instr       <= w_instr_nx;
            r_instr_pc    <= w_instr_pc_nx;
            r_instr_valid <= w_instr_valid_nx;
            r_drop_cnt    <= w_drop_cnt_nx;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nx       = r_state;
        w_addr_nx        = r_addr;
        w_drop_nx        = r_drop;
        w_instr_nx       = r_instr;
        w_instr_pc_nx    = r_instr_pc;
        w_instr_valid_nx = r_instr_valid;
        w_drop_cnt_nx    = r_drop_cnt;
        busy             = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (!halt) begin
                    w_state_nx = S_REQ;
                    w_addr_nx  = pc;
                    w_drop_nx  = 1'b0;
                end
            end
            S_REQ: begin
                // A redirect never withdraws the request; the response is dropped later
                if (flush) begin
                    w_drop_nx = 1'b1;
                end
                if (mem_ready) begin
                    w_state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (flush) begin
                    w_drop_nx = 1'b1;
                end
                if (mem_rvalid) begin
                    if (r_drop || flush) begin
                        if (r_drop_cnt != DROP_MAX) begin
                            w_drop_cnt_nx = r_drop_cnt + DROP_CNT_W'(1);
                        end
                        w_state_nx = S_IDLE;
                    end else begin
                        w_instr_nx       = mem_rdata;
                        w_instr_pc_nx    = r_addr;
                        w_instr_valid_nx = 1'b1;
                        w_state_nx       = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (flush) begin
                    w_instr_valid_nx = 1'b0;
                    w_state_nx       = S_IDLE;
                end else if (!id_stall) begin
                    busy             = 1'b0;
                    w_instr_valid_nx = 1'b0;
                    w_state_nx       = S_IDLE;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase

        w_mem_req_nx = (w_state_nx == S_REQ);
    end

    assign mem_req     = r_mem_req;
    assign mem_addr    = r_addr;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign instr_valid = r_instr_valid;
    assign drop_cnt    = r_drop_cnt;

endmodule

// File: tb/tb_rv32_ifetch.sv
// Directed bench for rv32_ifetch: drives a PC stage and memory responder, and
// checks both a default and a 2-bit drop counter instance against a fetch model.
module tb_rv32_ifetch;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        flush;
    logic        halt;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        id_stall;

    logic        busy, mem_req, instr_valid;
    logic [31:0] mem_addr, instr, instr_pc;
    logic [15:0] drop_cnt;

    logic        busy2, mem_req2, instr_valid2;
    logic [31:0] mem_addr2, instr2, instr_pc2;
    logic [1:0]  drop2;

    rv32_ifetch u_dut (
        .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush), .halt(halt),
        .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .id_stall(id_stall), .instr(instr), .instr_pc(instr_pc),
        .instr_valid(instr_valid), .drop_cnt(drop_cnt)
    );

    rv32_ifetch #(.DROP_CNT_W(2)) u_dut_w2 (
        .clk(clk), .rst_n(rst_n), .pc(pc), .flush(flush), .halt(halt),
        .busy(busy2), .mem_req(mem_req2), .mem_addr(mem_addr2),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .id_stall(id_stall), .instr(instr2), .instr_pc(instr_pc2),
        .instr_valid(instr_valid2), .drop_cnt(drop2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks;
    int n_errors;

    // Fetch model: one fetch record plus one delivered-instruction record
    bit          f_active, f_accepted, f_stale;
    logic [31:0] f_addr;
    bit          d_valid;
    logic [31:0] d_instr, d_pc;
    int          drops;

    // Memory responder and image
    logic [31:0] mem [256];
    int          req_age, out_cnt, ready_delay, rv_delay;
    bit          outstanding;
    logic [31:0] out_addr;

    function automatic int sat(input int v, input int m);
        return (v > m) ? m : v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, want);
        end
    endtask

    task automatic model_reset();
        f_active = 0; f_accepted = 0; f_stale = 0; f_addr = 32'h0;
        d_valid = 0; d_instr = 32'h0; d_pc = 32'h0; drops = 0;
    endtask

    // Contract applied at each clock edge with the inputs present at that edge
    task automatic model_edge();
        if (d_valid) begin
            if (flush || !id_stall) d_valid = 0;
        end else if (!f_active) begin
            if (!halt) begin
                f_active = 1; f_accepted = 0; f_stale = 0; f_addr = pc;
            end
        end else if (!f_accepted) begin
            if (flush) f_stale = 1;
            if (mem_ready) f_accepted = 1;
        end else if (mem_rvalid) begin
            if (f_stale || flush) drops++;
            else begin
                d_valid = 1; d_instr = mem_rdata; d_pc = f_addr;
            end
            f_active = 0;
        end else if (flush) begin
            f_stale = 1;
        end
    endtask

    task automatic compare_all();
        logic [31:0] e_busy, e_req;
        e_busy = 32'(!(d_valid && !id_stall && !flush));
        e_req  = 32'(f_active && !f_accepted);
        chk("busy", 32'(busy), e_busy);
        chk("mem_req", 32'(mem_req), e_req);
        chk("mem_addr", mem_addr, f_addr);
        chk("instr_valid", 32'(instr_valid), 32'(d_valid));
        chk("instr", instr, d_instr);
        chk("instr_pc", instr_pc, d_pc);
        chk("drop_cnt", 32'(drop_cnt), 32'(sat(drops, 65535)));
        chk("w2_busy", 32'(busy2), e_busy);
        chk("w2_mem_req", 32'(mem_req2), e_req);
        chk("w2_mem_addr", mem_addr2, f_addr);
        chk("w2_instr_valid", 32'(instr_valid2), 32'(d_valid));
        chk("w2_instr", instr2, d_instr);
        chk("w2_instr_pc", instr_pc2, d_pc);
        chk("w2_drop_cnt", 32'(drop2), 32'(sat(drops, 3)));
    endtask

    // Called at a falling edge: let inputs settle, then compare
    task automatic sample();
        #1;
        compare_all();
    endtask

    // Clock edge: model update, then PC stage and memory react to the new state
    task automatic advance();
        bit          b_pre, acc_pre, rv_pre;
        logic [31:0] addr_pre;
        b_pre    = busy;
        acc_pre  = mem_req && mem_ready;
        rv_pre   = mem_rvalid;
        addr_pre = mem_addr;
        @(posedge clk);
        if (rst_n) model_edge();
        #1;
        if (!b_pre) pc = pc + 32'd1;
        if (rv_pre) outstanding = 0;
        if (acc_pre) begin
            outstanding = 1; out_cnt = 0; out_addr = addr_pre;
        end else if (outstanding) begin
            out_cnt++;
        end
        mem_rvalid = outstanding && (out_cnt == rv_delay);
        mem_rdata  = mem_rvalid ? mem[out_addr[7:0]] : 32'h0;
        if (!mem_req) req_age = 0;
        mem_ready = mem_req && !outstanding && (req_age >= ready_delay);
        if (mem_req) req_age++;
        @(negedge clk);
    endtask

    task automatic cyc();
        sample();
        advance();
    endtask

    // Ends on a sampled cycle where the condition holds (kind 0: mem_req, 1: instr_valid)
    task automatic wait_until(input int kind, input int budget);
        bit hit;
        hit = 0;
        for (int i = 0; i < budget; i++) begin
            sample();
            hit = (kind == 0) ? mem_req : instr_valid;
            if (hit) break;
            advance();
        end
        if (!hit) begin
            n_checks++;
            n_errors++;
            $display("FAIL wait_%0d: condition not reached within %0d cycles", kind, budget);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | 32'(i);
        mem[8'h10] = 32'h0050_0093;
        mem[8'h12] = 32'hDEAD_BEEF;
        mem[8'h40] = 32'h1234_5678;
        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; pc = 32'h10; flush = 1'b0; halt = 1'b0; id_stall = 1'b0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        req_age = 0; out_cnt = 0; ready_delay = 0; rv_delay = 0;
        outstanding = 0; out_addr = 32'h0;
        model_reset();
        @(negedge clk);

        sample();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        advance();
        cyc();
        rst_n = 1'b1;

        // Basic fetch, best-case latency
        sample(); chk("c0_mem_req", 32'(mem_req), 32'd0); advance();
        sample(); chk("c1_mem_req", 32'(mem_req), 32'd1); chk("c1_mem_addr", mem_addr, 32'h10); advance();
        cyc();
        sample();
        chk("c3_valid", 32'(instr_valid), 32'd1);
        chk("c3_instr", instr, 32'h0050_0093);
        chk("c3_instr_pc", instr_pc, 32'h10);
        chk("c3_busy", 32'(busy), 32'd0);
        advance();
        sample(); chk("c4_valid", 32'(instr_valid), 32'd0); chk("c4_mem_req", 32'(mem_req), 32'd0); advance();
        sample(); chk("c5_mem_req", 32'(mem_req), 32'd1); chk("c5_mem_addr", mem_addr, 32'h11); advance();

        // Downstream stall for three HOLD cycles
        id_stall = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            sample();
            chk("stall_valid", 32'(instr_valid), 32'd1);
            chk("stall_instr", instr, 32'hA500_0011);
            chk("stall_pc", instr_pc, 32'h11);
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_mem_req", 32'(mem_req), 32'd0);
            advance();
        end
        id_stall = 1'b0;
        sample(); chk("release_busy", 32'(busy), 32'd0); advance();
        sample(); chk("after_busy", 32'(busy), 32'd1); chk("after_valid", 32'(instr_valid), 32'd0); advance();

        // Flush while waiting for the response
        rv_delay = 2;
        wait_until(0, 20);
        chk("fw_req_addr", mem_addr, 32'h12);
        advance();
        flush = 1'b1; pc = 32'h40;
        cyc();
        flush = 1'b0;
        for (int k = 0; k < 3; k++) begin
            sample(); chk("fw_valid", 32'(instr_valid), 32'd0); advance();
        end
        sample();
        chk("fw_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("fw_drop2", 32'(drop2), 32'd1);
        chk("fw_next_req", 32'(mem_req), 32'd1);
        chk("fw_next_addr", mem_addr, 32'h40);
        rv_delay = 0;
        id_stall = 1'b1;
        advance();

        // Flush while holding a stalled instruction
        wait_until(1, 10);
        chk("fh_instr", instr, 32'h1234_5678);
        chk("fh_pc", instr_pc, 32'h40);
        advance();
        flush = 1'b1; pc = 32'h50;
        sample(); chk("fh_busy", 32'(busy), 32'd1); advance();
        flush = 1'b0;
        sample();
        chk("fh_valid", 32'(instr_valid), 32'd0);
        chk("fh_busy_after", 32'(busy), 32'd1);
        chk("fh_drop_cnt", 32'(drop_cnt), 32'd1);
        advance();
        sample(); chk("fh_req", 32'(mem_req), 32'd1); chk("fh_addr", mem_addr, 32'h50);
        id_stall = 1'b0;
        advance();

        // Halt in IDLE blocks new requests
        wait_until(1, 10);
        chk("hi_pc", instr_pc, 32'h50);
        halt = 1'b1;
        advance();
        for (int k = 0; k < 10; k++) begin
            sample(); chk("halt_idle_req", 32'(mem_req), 32'd0); advance();
        end

        // Halt raised in WAIT still delivers the instruction
        halt = 1'b0; rv_delay = 2;
        wait_until(0, 5);
        chk("hw_addr", mem_addr, 32'h51);
        advance();
        halt = 1'b1;
        wait_until(1, 10);
        chk("hw_instr", instr, 32'hA500_0051);
        chk("hw_pc", instr_pc, 32'h51);
        advance();
        for (int k = 0; k < 8; k++) begin
            sample(); chk("halt_wait_req", 32'(mem_req), 32'd0); advance();
        end

        // Back-pressure: ready low for five REQ cycles
        halt = 1'b0; rv_delay = 0; ready_delay = 5;
        wait_until(0, 5);
        for (int k = 0; k < 5; k++) begin
            chk("bp_req", 32'(mem_req), 32'd1);
            chk("bp_addr", mem_addr, 32'h52);
            advance();
            sample();
        end
        chk("bp_req_last", 32'(mem_req), 32'd1);
        chk("bp_addr_last", mem_addr, 32'h52);
        ready_delay = 0;
        advance();
        wait_until(1, 10);
        chk("bp_pc", instr_pc, 32'h52);
        advance();

        // Five discarded responses saturate the 2-bit counter
        rv_delay = 1;
        for (int i = 0; i < 5; i++) begin
            wait_until(0, 10);
            if (i == 0) begin
                flush = 1'b1;
                advance();
                flush = 1'b0;
            end else begin
                advance();
                flush = 1'b1;
                cyc();
                flush = 1'b0;
            end
        end
        cyc();
        sample();
        chk("sat_drop_cnt", 32'(drop_cnt), 32'd6);
        chk("sat_drop2", 32'(drop2), 32'd3);
        chk("sat_valid", 32'(instr_valid), 32'd0);
        advance();

        // Reset mid-transaction, then a late response is ignored
        rv_delay = 3;
        wait_until(0, 10);
        advance();
        rst_n = 1'b0;
        model_reset();
        sample();
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_valid", 32'(instr_valid), 32'd0);
        chk("mid_rst_drop", 32'(drop_cnt), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd1);
        advance();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) cyc();
        wait_until(1, 20);
        chk("late_pc", instr_pc, 32'h53);
        chk("late_instr", instr, 32'hA500_0053);
        chk("late_drop", 32'(drop_cnt), 32'd0);
        advance();
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
